multicycle_ctrl: RTL and testbench

- Multicycle main control FSM. It is the initiator on the alu_op/funct interface consumed by the ALU control decoder.
- Sequences FETCH/DECODE/execute/memory/writeback per instruction, handshakes with memory via mem_req/mem_ready, and drives all datapath enables and muxes.
- Sits between the instruction register (opcode, funct fields) and the datapath plus ALU control decoder.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
// Opcode values, ALU-op and mux select codes used by the controller and its neighbours.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_ORI   = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with memory and drives datapath enables, mux selects and ALU-op.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_req,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write_en,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [FUNCT_W-1:0] funct,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_seen,
  output logic [3:0]         state_o
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic op_r, op_lw, op_sw, op_beq, op_addi, op_ori, op_j, op_legal;

  assign op_r     = (opcode == OP_W'(OP_RTYPE));
  assign op_lw    = (opcode == OP_W'(OP_LW));
  assign op_sw    = (opcode == OP_W'(OP_SW));
  assign op_beq   = (opcode == OP_W'(OP_BEQ));
  assign op_addi  = (opcode == OP_W'(OP_ADDI));
  assign op_ori   = (opcode == OP_W'(OP_ORI));
  assign op_j     = (opcode == OP_W'(OP_J));
  assign op_legal = op_r | op_lw | op_sw | op_beq | op_addi | op_ori | op_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = illegal_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (op_r)                       state_d = EXEC;
        else if (op_lw || op_sw)        state_d = MEMADR;
        else if (op_beq)                state_d = BRANCH;
        else if (op_addi || op_ori)     state_d = IEXEC;
        else if (op_j)                  state_d = JUMP;
        else begin
          state_d   = FETCH;
          illegal_d = 1'b1;
        end
      end
      // Opcode is held from DECODE, so only LW/SW can be seen here.
      MEMADR: state_d = op_sw ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      IEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write_en = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    alu_op      = ALUOP_FUNCT;
    funct       = '0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = SRCB_ONE;
        alu_op      = ALUOP_ADD;
        ir_write    = mem_ready;
        pc_write_en = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_BOFF;
        alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALUOP_FUNCT;
        funct     = funct_in;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REGB;
        alu_op      = ALUOP_SUB;
        pc_src      = PCSRC_ALUOUT;
        pc_write_en = zero;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = op_ori ? ALUOP_OR : ALUOP_ADD;
      end
      IWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src      = PCSRC_JUMP;
        pc_write_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_seen = illegal_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle scripts are expanded into a queue of
// expected per-cycle outputs, then replayed against the DUT with random waits and opcodes.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic [3:0] funct_in = '0;
  logic       mem_ready = 1'b1;
  logic       zero = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, pc_write_en;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_seen;
  logic [3:0] funct, state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(4), .FUNCT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct_in(funct_in),
    .mem_ready(mem_ready), .zero(zero), .mem_req(mem_req), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write_en(pc_write_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .funct(funct),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_seen(illegal_seen), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, mem_write, iord, ir_write, pc_write_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] funct;
    logic       reg_write, reg_dst, mem_to_reg, illegal_seen;
  } obs_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] fn;
    logic       mr;
    logic       zr;
    obs_t       e;
  } step_t;

  obs_t  obs;
  step_t plan[$];
  logic  model_ill = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  assign obs = {state_o, mem_req, mem_write, iord, ir_write, pc_write_en, pc_src, alu_src_a,
                alu_src_b, alu_op, funct, reg_write, reg_dst, mem_to_reg, illegal_seen};

  function automatic obs_t blank(input state_t st);
    obs_t e;
    e = '0;
    e.state = 4'(st);
    e.illegal_seen = model_ill;
    return e;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] fn, input logic mr,
                      input logic zr, input obs_t e);
    step_t s;
    s.op = op; s.fn = fn; s.mr = mr; s.zr = zr; s.e = e;
    plan.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycle-by-cycle outputs.
  task automatic add_instr(input logic [3:0] op, input logic [3:0] fn, input logic z,
                           input int fw, input int mw);
    obs_t e;
    logic mr;
    for (int i = 0; i <= fw; i++) begin
      mr = (i == fw);
      e = blank(FETCH);
      e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 2'b10;
      e.ir_write = mr; e.pc_write_en = mr;
      push(op, fn, mr, rbit(), e);
    end
    e = blank(DECODE);
    e.alu_src_b = 2'b11; e.alu_op = 2'b10;
    push(op, fn, rbit(), rbit(), e);
    case (op)
      4'd0: begin
        e = blank(EXEC);
        e.alu_src_a = 1'b1; e.alu_op = 2'b00; e.funct = fn;
        push(op, fn, rbit(), rbit(), e);
        e = blank(ALUWB);
        e.reg_write = 1'b1; e.reg_dst = 1'b1;
        push(op, fn, rbit(), rbit(), e);
      end
      4'd1, 4'd2: begin
        e = blank(MEMADR);
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b10;
        push(op, fn, rbit(), rbit(), e);
        for (int i = 0; i <= mw; i++) begin
          e = blank(op == 4'd1 ? MEMRD : MEMWR);
          e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (op == 4'd2);
          push(op, fn, i == mw, rbit(), e);
        end
        if (op == 4'd1) begin
          e = blank(MEMWB);
          e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          push(op, fn, rbit(), rbit(), e);
        end
      end
      4'd3: begin
        e = blank(BRANCH);
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write_en = z;
        push(op, fn, rbit(), z, e);
      end
      4'd4, 4'd5: begin
        e = blank(IEXEC);
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = (op == 4'd5) ? 2'b11 : 2'b10;
        push(op, fn, rbit(), rbit(), e);
        e = blank(IWB);
        e.reg_write = 1'b1;
        push(op, fn, rbit(), rbit(), e);
      end
      4'd6: begin
        e = blank(JUMP);
        e.pc_src = 2'b10; e.pc_write_en = 1'b1;
        push(op, fn, rbit(), rbit(), e);
      end
      default: model_ill = 1'b1;
    endcase
  endtask

  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      s = plan.pop_front();
      @(negedge clk);
      opcode = s.op; funct_in = s.fn; mem_ready = s.mr; zero = s.zr;
      #1;
      cyc++;
      check($sformatf("cyc%0d_op%0h", cyc, s.op), obs, s.e);
    end
  endtask

  task automatic run_all();
    run_steps(plan.size());
  endtask

  initial begin
    logic [3:0] rop;
    // Reset held: IDLE with everything low even when mem_ready is high.
    @(negedge clk); #1;
    check("reset_idle", obs, blank(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_idle", obs, blank(IDLE));

    add_instr(4'd0, 4'b0010, 1'b0, 2, 0); run_all();   // R-type, FETCH stalls 2 cycles
    add_instr(4'd1, 4'b1010, 1'b0, 0, 0); run_all();   // LW
    add_instr(4'd3, 4'b0000, 1'b1, 0, 0); run_all();   // BEQ taken
    add_instr(4'd3, 4'b0000, 1'b0, 0, 0); run_all();   // BEQ not taken
    add_instr(4'd5, 4'b0111, 1'b0, 0, 0); run_all();   // ORI
    add_instr(4'd15, 4'b0101, 1'b0, 0, 0); run_all();  // illegal
    add_instr(4'd6, 4'b0000, 1'b0, 1, 0); run_all();   // J
    add_instr(4'd2, 4'b0011, 1'b0, 0, 2); run_all();   // SW with memory wait

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) rop = 4'($urandom_range(7, 15));
      else rop = 4'($urandom_range(0, 6));
      add_instr(rop, 4'($urandom), rbit(), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      run_all();
    end

    // SW interrupted by reset while MEMWR is still waiting.
    add_instr(4'd2, 4'b0001, 1'b0, 0, 5);
    run_steps(5);
    #2 rst_n = 1'b0;
    #1;
    model_ill = 1'b0;
    plan.delete();
    check("reset_mid_write", obs, blank(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rerelease_idle", obs, blank(IDLE));
    add_instr(4'd4, 4'b0000, 1'b0, 1, 0); run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
